// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, addresses the instruction ROM and
// fills the IF/ID pipeline register under stall/flush control.
// Optional interrupt entry is built when IF_IRQ_EN is defined.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
`ifdef IF_IRQ_EN
    parameter logic [31:0] IRQ_VECTOR = 32'h8000_0004,
`endif
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        flush,
    input  logic [1:0]  pc_src,
    input  logic [31:0] branch_target,
    input  logic [25:0] jump_index,
    input  logic [31:0] jr_target,
    output logic [31:0] rom_addr,
    input  logic [31:0] rom_data,
`ifdef IF_IRQ_EN
    input  logic        irq,
    output logic [31:0] irq_epc,
`endif
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc_plus4,
    output logic        ifid_valid
);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [31:0] pc_plus4;
    logic [31:0] mux_raw;
    logic [31:0] mux_pc;
    logic        ifid_bubble;
`ifdef IF_IRQ_EN
    logic        take_irq;
`endif

    assign rom_addr = pc_q;

    // Next-PC selection; low two bits cleared so fetches stay word-aligned.
    always_comb begin
        pc_plus4 = pc_q + 32'd4;
        mux_raw  = pc_plus4;
        unique case (pc_src)
            2'b00: mux_raw = pc_plus4;
            2'b01: mux_raw = branch_target;
            2'b10: mux_raw = {ifid_pc_plus4[31:28], jump_index, 2'b00};
            2'b11: mux_raw = jr_target;
            default: mux_raw = pc_plus4;
        endcase
        mux_pc = mux_raw & 32'hFFFF_FFFC;
    end

    // Stall holds the PC; an accepted interrupt overrides any redirect.
    always_comb begin
`ifdef IF_IRQ_EN
        // Interrupts are only taken from user space (pc[31]=0) and never while stalled.
        take_irq    = irq && !pc_q[31] && !stall;
        ifid_bubble = flush || take_irq;
        if (stall) begin
            pc_d = pc_q;
        end else if (take_irq) begin
            pc_d = IRQ_VECTOR;
        end else begin
            pc_d = mux_pc;
        end
`else
        ifid_bubble = flush;
        pc_d        = stall ? pc_q : mux_pc;
`endif
    end

    // Program counter register.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    // IF/ID register: flush beats stall, which beats a normal load.
    always_ff @(posedge clk) begin
        if (reset) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= RESET_PC + 32'd4;
            ifid_valid    <= 1'b0;
        end else if (ifid_bubble) begin
            ifid_instr    <= NOP_INSTR;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b0;
        end else if (!stall) begin
            ifid_instr    <= rom_data;
            ifid_pc_plus4 <= pc_plus4;
            ifid_valid    <= 1'b1;
        end
    end

`ifdef IF_IRQ_EN
    // Return address is the PC that the interrupt displaced.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_epc <= 32'h0000_0000;
        end else if (take_irq) begin
            irq_epc <= mux_pc;
        end
    end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: directed test-plan steps followed by
// randomized cycles, all checked against a cycle-level reference model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC   = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] IRQ_VECTOR = 32'h8000_0004;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic [1:0]  pc_src = 2'b00;
    logic [31:0] branch_target = '0;
    logic [25:0] jump_index = '0;
    logic [31:0] jr_target = '0;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] ifid_instr;
    logic [31:0] ifid_pc_plus4;
    logic        ifid_valid;
    logic        irq = 1'b0;
`ifdef IF_IRQ_EN
    logic [31:0] irq_epc;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_instr, m_pc4, m_epc;
    logic        m_valid;

    if_stage dut (
        .clk          (clk),
        .reset        (reset),
        .stall        (stall),
        .flush        (flush),
        .pc_src       (pc_src),
        .branch_target(branch_target),
        .jump_index   (jump_index),
        .jr_target    (jr_target),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
`ifdef IF_IRQ_EN
        .irq          (irq),
        .irq_epc      (irq_epc),
`endif
        .ifid_instr   (ifid_instr),
        .ifid_pc_plus4(ifid_pc_plus4),
        .ifid_valid   (ifid_valid)
    );

    always #5 clk = ~clk;

    // Distinct, address-dependent ROM contents
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0] ^ 16'h1357, a[31:16] ^ 16'hC0DE};
    endfunction

    assign rom_data = rom_word(rom_addr);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, advance the model, check all outputs after the edge.
    task automatic step(input logic r, input logic s, input logic f, input logic [1:0] ps,
                        input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jt,
                        input logic iq);
        logic [31:0] tgt;
        logic        tk;
        reset = r; stall = s; flush = f; pc_src = ps;
        branch_target = bt; jump_index = ji; jr_target = jt; irq = iq;
        tk = 1'b0;
        if (r) begin
            m_pc = RESET_PC; m_instr = NOP_INSTR; m_valid = 1'b0;
            m_pc4 = RESET_PC + 32'd4; m_epc = 32'h0;
        end else begin
            case (ps)
                2'd0: tgt = m_pc + 32'd4;
                2'd1: tgt = bt;
                2'd2: tgt = {m_pc4[31:28], 28'(ji) * 28'd4};
                default: tgt = jt;
            endcase
            tgt = (tgt / 4) * 4;
`ifdef IF_IRQ_EN
            tk = iq && (m_pc < 32'h8000_0000) && !s;
`endif
            if (f || tk) begin
                m_instr = NOP_INSTR; m_valid = 1'b0; m_pc4 = m_pc + 32'd4;
            end else if (!s) begin
                m_instr = rom_word(m_pc); m_valid = 1'b1; m_pc4 = m_pc + 32'd4;
            end
            if (tk) m_epc = tgt;
            if (!s) m_pc = tk ? IRQ_VECTOR : tgt;
        end
        @(posedge clk);
        #1;
        chk("rom_addr", rom_addr, m_pc);
        chk("ifid_instr", ifid_instr, m_instr);
        chk("ifid_pc_plus4", ifid_pc_plus4, m_pc4);
        chk("ifid_valid", 32'(ifid_valid), 32'(m_valid));
`ifdef IF_IRQ_EN
        chk("irq_epc", irq_epc, m_epc);
`endif
    endtask

    initial begin
        // Reset held two cycles
        step(1, 0, 0, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", rom_addr, 32'h0);
        chk("rst_valid", 32'(ifid_valid), 32'h0);
        chk("rst_pc4", ifid_pc_plus4, 32'h4);
        // Sequential fetch
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_addr4", rom_addr, 32'h4);
        chk("seq_valid", 32'(ifid_valid), 32'h1);
        chk("seq_pc4", ifid_pc_plus4, 32'h4);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("seq_addrC", rom_addr, 32'hC);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        // Stall at 0x10
        step(0, 1, 0, 1, 32'h100, 0, 0, 0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        chk("stall_addr", rom_addr, 32'h10);
        chk("stall_pc4", ifid_pc_plus4, 32'h10);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("unstall_addr", rom_addr, 32'h14);
        // Branch with flush
        step(0, 0, 1, 1, 32'h40, 0, 0, 0);
        chk("br_addr", rom_addr, 32'h40);
        chk("br_instr", ifid_instr, 32'h0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("br_load", ifid_instr, rom_word(32'h40));
        // Jump from ifid_pc_plus4 = 0x1000_0010
        step(0, 0, 0, 3, 0, 0, 32'h1000_000C, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 2, 0, 26'd11, 0, 0);
        chk("jump_addr", rom_addr, 32'h1000_002C);
        step(0, 0, 0, 3, 0, 0, 32'h0000_0123, 0);
        chk("jr_align", rom_addr, 32'h0000_0120);
        // Stall plus flush with redirect
        step(0, 1, 1, 1, 32'h500, 0, 0, 0);
        chk("sf_addr", rom_addr, 32'h120);
        chk("sf_valid", 32'(ifid_valid), 32'h0);
        // PC wrap
        step(0, 0, 0, 3, 0, 0, 32'hFFFF_FFFC, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        chk("wrap_addr", rom_addr, 32'h0);
`ifdef IF_IRQ_EN
        step(0, 0, 0, 3, 0, 0, 32'h20, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("irq_pc", rom_addr, 32'h8000_0004);
        chk("irq_epc_val", irq_epc, 32'h24);
        step(0, 0, 0, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 1);
        chk("irq_kernel", rom_addr, 32'h8000_000C);
`endif
        // Reset mid-operation overrides everything
        step(1, 1, 1, 3, 32'h77, 26'h3, 32'h99, 1);
        chk("midrst_pc", rom_addr, RESET_PC);
        // Randomized cycles
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)),
                 $urandom, 26'($urandom), $urandom, ($urandom_range(0, 9) == 0));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
